// File: rtl/mux4_rr_sel_arbiter.sv
// rtl/mux4_rr_sel_arbiter.sv - round-robin arbiter and burst-metered select sequencer for a 4:1 mux
module mux4_rr_sel_arbiter #(
    parameter int BURST_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       out_ready,
    output logic       s1,
    output logic       s0,
    output logic [3:0] gnt,
    output logic       out_valid,
    output logic       out_last
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        cur, cur_nxt;
    logic [1:0]        ptr, ptr_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [3:0]        gnt_nxt;

    logic [1:0]        pick;
    logic              pick_ok;
    logic [1:0]        idx;
    logic              xfer;
    logic              release_now;

    // Scan from the furthest offset back to ptr so the nearest requester wins.
    always_comb begin
        pick    = ptr;
        pick_ok = 1'b0;
        idx     = '0;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                pick    = idx;
                pick_ok = 1'b1;
            end
        end
    end

    assign out_valid   = (state == GRANT) && req[cur];
    assign out_last    = out_valid && (count == LAST_BEAT);
    assign xfer        = out_valid && out_ready;
    assign release_now = (state == GRANT) && (!req[cur] || (xfer && count == LAST_BEAT));

    assign s1 = cur[1];
    assign s0 = cur[0];

    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        ptr_nxt   = ptr;
        count_nxt = count;
        gnt_nxt   = gnt;
        case (state)
            IDLE: begin
                if (pick_ok) begin
                    state_nxt = GRANT;
                    cur_nxt   = pick;
                    ptr_nxt   = pick + 2'd1;
                    count_nxt = '0;
                    gnt_nxt   = 4'b0001 << pick;
                end
            end
            GRANT: begin
                if (release_now) begin
                    count_nxt = '0;
                    if (pick_ok) begin
                        // Back-to-back handover; ptr already points past the released channel.
                        cur_nxt = pick;
                        ptr_nxt = pick + 2'd1;
                        gnt_nxt = 4'b0001 << pick;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = 4'b0000;
                    end
                end else if (xfer) begin
                    count_nxt = count + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
                count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cur   <= 2'd0;
            ptr   <= 2'd0;
            count <= '0;
            gnt   <= 4'b0000;
        end else begin
            state <= state_nxt;
            cur   <= cur_nxt;
            ptr   <= ptr_nxt;
            count <= count_nxt;
            gnt   <= gnt_nxt;
        end
    end

endmodule

// File: tb/tb_mux4_rr_sel_arbiter.sv
// tb/tb_mux4_rr_sel_arbiter.sv - directed self-checking bench for mux4_rr_sel_arbiter
module tb_mux4_rr_sel_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       out_ready;
    logic       s1, s0;
    logic [3:0] gnt;
    logic       out_valid, out_last;

    logic [3:0] req1;
    logic       out_ready1;
    logic       s1_1, s0_1;
    logic [3:0] gnt1;
    logic       out_valid1, out_last1;

    int checks = 0;
    int errors = 0;

    mux4_rr_sel_arbiter #(.BURST_LEN(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .s1(s1), .s0(s0), .gnt(gnt), .out_valid(out_valid), .out_last(out_last)
    );

    mux4_rr_sel_arbiter #(.BURST_LEN(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .out_ready(out_ready1),
        .s1(s1_1), .s0(s0_1), .gnt(gnt1), .out_valid(out_valid1), .out_last(out_last1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 4'b0000; out_ready = 1'b0; req1 = 4'b0000; out_ready1 = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        req = 4'b0000; out_ready = 1'b0; req1 = 4'b0000; out_ready1 = 1'b0;
        rst_n = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0000 || out_valid !== 1'b0 || {s1, s0} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: gnt=%b valid=%b sel=%b want 0000/0/00", gnt, out_valid, {s1, s0});
        end
        rst_n = 1'b1;
        req = 4'b0100;
        tick();
        #1;
        checks++;
        if (gnt !== 4'b0100 || {s1, s0} !== 2'b10 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_grant2: gnt=%b sel=%b valid=%b want 0100/10/1", gnt, {s1, s0}, out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000 || out_valid !== 1'b0 || out_last !== 1'b0 || {s1, s0} !== 2'b00) begin
            errors++;
            $display("FAIL reset_async: gnt=%b valid=%b last=%b sel=%b want 0000/0/0/00",
                     gnt, out_valid, out_last, {s1, s0});
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL reset_regrant: gnt=%b want 0100", gnt);
        end
    endtask

    task automatic test_full_burst();
        do_reset();
        req = 4'b0001; out_ready = 1'b1;
        tick();
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (gnt !== 4'b0001 || {s1, s0} !== 2'b00 || out_valid !== 1'b1 || out_last !== (b == 3)) begin
                errors++;
                $display("FAIL burst_beat%0d: gnt=%b sel=%b valid=%b last=%b want 0001/00/1/%0d",
                         b, gnt, {s1, s0}, out_valid, out_last, (b == 3));
            end
            tick();
        end
        checks++;
        if (gnt !== 4'b0001 || out_valid !== 1'b1 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL burst_regrant: gnt=%b valid=%b last=%b want 0001/1/0", gnt, out_valid, out_last);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_gnt;
        do_reset();
        req = 4'b1111; out_ready = 1'b1;
        tick();
        for (int g = 0; g < 5; g++) begin
            exp_gnt = 4'b0001 << (g % 4);
            for (int b = 0; b < 4; b++) begin
                checks++;
                if (gnt !== exp_gnt || {s1, s0} !== 2'(g % 4) || out_valid !== 1'b1 || out_last !== (b == 3)) begin
                    errors++;
                    $display("FAIL rotate_g%0d_b%0d: gnt=%b sel=%b valid=%b last=%b want %b/%0d/1/%0d",
                             g, b, gnt, {s1, s0}, out_valid, out_last, exp_gnt, g % 4, (b == 3));
                end
                tick();
            end
        end
    endtask

    task automatic test_backpressure();
        logic [6:0] rdy_pat;
        logic [6:0] last_pat;
        int xfers;
        rdy_pat  = 7'b1011001;
        last_pat = 7'b1100000;
        xfers = 0;
        do_reset();
        req = 4'b0010; out_ready = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) begin
            out_ready = rdy_pat[i];
            #1;
            if (out_valid && out_ready) xfers++;
            checks++;
            if (gnt !== 4'b0010 || {s1, s0} !== 2'b01 || out_last !== last_pat[i]) begin
                errors++;
                $display("FAIL bp_cycle%0d: gnt=%b sel=%b last=%b want 0010/01/%b",
                         i, gnt, {s1, s0}, out_last, last_pat[i]);
            end
            tick();
        end
        checks++;
        if (xfers !== 4) begin
            errors++;
            $display("FAIL bp_transfers: got %0d want 4", xfers);
        end
    endtask

    task automatic test_withdrawal();
        int lasts;
        lasts = 0;
        do_reset();
        req = 4'b1000; out_ready = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b1000 || {s1, s0} !== 2'b11) begin
            errors++;
            $display("FAIL wd_grant3: gnt=%b sel=%b want 1000/11", gnt, {s1, s0});
        end
        for (int b = 0; b < 2; b++) begin
            if (out_last) lasts++;
            tick();
        end
        req = 4'b0001;
        #1;
        if (out_last) lasts++;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wd_valid_drop: valid=%b want 0", out_valid);
        end
        tick();
        checks++;
        if (gnt !== 4'b0001 || {s1, s0} !== 2'b00) begin
            errors++;
            $display("FAIL wd_next: gnt=%b sel=%b want 0001/00", gnt, {s1, s0});
        end
        checks++;
        if (lasts !== 0) begin
            errors++;
            $display("FAIL wd_no_last: got %0d last beats want 0", lasts);
        end
    endtask

    task automatic test_wrap_priority();
        do_reset();
        req = 4'b0100; out_ready = 1'b0;
        tick();
        req = 4'b1001;
        tick();
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_first: gnt=%b want 1000", gnt);
        end
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) tick();
        checks++;
        if (gnt !== 4'b0001 || {s1, s0} !== 2'b00) begin
            errors++;
            $display("FAIL wrap_second: gnt=%b sel=%b want 0001/00", gnt, {s1, s0});
        end
    endtask

    task automatic test_burst_one();
        logic [3:0] exp_gnt;
        do_reset();
        req1 = 4'b0110; out_ready1 = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            exp_gnt = (i % 2 == 0) ? 4'b0010 : 4'b0100;
            checks++;
            if (gnt1 !== exp_gnt || out_valid1 !== 1'b1 || out_last1 !== 1'b1) begin
                errors++;
                $display("FAIL b1_beat%0d: gnt=%b valid=%b last=%b want %b/1/1",
                         i, gnt1, out_valid1, out_last1, exp_gnt);
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req = 4'b0000; out_ready = 1'b0; req1 = 4'b0000; out_ready1 = 1'b0;
        test_reset();
        test_full_burst();
        test_rotation();
        test_backpressure();
        test_withdrawal();
        test_wrap_priority();
        test_burst_one();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
